// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the 2-way set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  typedef logic way_t;

  localparam int ADDR_W_DEF   = 8;
  localparam int SET_BITS_DEF = 2;
  localparam int TAG_W        = ADDR_W_DEF - SET_BITS_DEF;
  localparam int NSETS        = 1 << SET_BITS_DEF;

  function automatic way_t other_way(input way_t w);
    return ~w;
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One way of the cache: valid/tag/data per set, combinational read, synchronous write.
module dcache_way_array
  import dcache_pkg::*;
#(
  parameter int SET_W   = SET_BITS_DEF,
  parameter int TAG_LEN = TAG_W,
  parameter int ROWS    = NSETS,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SET_W-1:0]   rd_set,
  output logic               rd_valid,
  output logic [TAG_LEN-1:0] rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [SET_W-1:0]   wr_set,
  input  logic [TAG_LEN-1:0] wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  logic [ROWS-1:0]    valid_q;
  logic [TAG_LEN-1:0] tag_q  [ROWS];
  logic [DATA_W-1:0]  data_q [ROWS];

  // Only the valid bits need clearing; tag/data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      tag_q[wr_set]  <= wr_tag;
      data_q[wr_set] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_set];
  assign rd_tag   = tag_q[rd_set];
  assign rd_data  = data_q[rd_set];

endmodule

// File: rtl/dcache_assoc.sv
// 2-way set-associative, write-through, no-write-allocate data cache with true LRU.
// Handshakes: a CPU access completes in the cycle cpu_req & cpu_ready; a memory
// transfer is mem_req held high until the cycle mem_ack pulses, then drops.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int SET_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output state_t            dbg_state
);

  localparam int TAG_BITS = ADDR_W - SET_BITS;
  localparam int SETS     = 1 << SET_BITS;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0] tag_in;
  assign set_idx = cpu_addr[SET_BITS-1:0];
  assign tag_in  = cpu_addr[ADDR_W-1:SET_BITS];

  logic [1:0]          way_valid;
  logic [TAG_BITS-1:0] way_tag  [2];
  logic [DATA_W-1:0]   way_data [2];
  logic [1:0]          way_wr;
  logic [DATA_W-1:0]   wr_data;

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way_array #(
      .SET_W  (SET_BITS),
      .TAG_LEN(TAG_BITS),
      .ROWS   (SETS),
      .DATA_W (DATA_W)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .rd_set  (set_idx),
      .rd_valid(way_valid[w]),
      .rd_tag  (way_tag[w]),
      .rd_data (way_data[w]),
      .wr_en   (way_wr[w]),
      .wr_set  (set_idx),
      .wr_tag  (tag_in),
      .wr_data (wr_data)
    );
  end

  state_t              state_q, state_d;
  logic [SETS-1:0]     lru_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rdata_q, rd_out;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [1:0]          hit_w;
  way_t                hit_way, victim, lru_new;
  logic [DATA_W-1:0]   hit_data;
  logic                lru_upd, start_rd, start_wr, done, hit_inc, miss_inc;

  always_comb begin
    hit_w = '0;
    for (int w = 0; w < 2; w++) begin
      hit_w[w] = way_valid[w] && (way_tag[w] == tag_in);
    end
  end

  assign hit      = |hit_w;
  assign hit_way  = hit_w[1];
  assign hit_data = hit_w[1] ? way_data[1] : way_data[0];

  // Fill prefers an empty way (lowest first); otherwise the set's LRU way.
  always_comb begin
    if (!way_valid[0])      victim = 1'b0;
    else if (!way_valid[1]) victim = 1'b1;
    else                    victim = lru_q[set_idx];
  end

  assign wr_data = (state_q == FILL) ? mem_rdata : mem_wdata_q;

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    rd_out    = rdata_q;
    way_wr    = '0;
    lru_upd   = 1'b0;
    lru_new   = 1'b0;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    done      = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cpu_req) begin
          cpu_ready = 1'b1;
        end else if (cpu_we) begin
          start_wr = 1'b1;
          state_d  = WRITE;
        end else if (hit) begin
          cpu_ready = 1'b1;
          rd_out    = hit_data;
          lru_upd   = 1'b1;
          lru_new   = other_way(hit_way);
          hit_inc   = 1'b1;
        end else begin
          start_rd = 1'b1;
          miss_inc = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          way_wr[victim] = 1'b1;
          lru_upd        = 1'b1;
          lru_new        = other_way(victim);
          cpu_ready      = 1'b1;
          rd_out         = mem_rdata;
          done           = 1'b1;
          state_d        = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          if (hit) begin
            way_wr[hit_way] = 1'b1;
            lru_upd         = 1'b1;
            lru_new         = other_way(hit_way);
          end
          cpu_ready = 1'b1;
          done      = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      lru_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rd_out;
      if (lru_upd) lru_q[set_idx] <= lru_new;
      if (start_rd) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= cpu_addr;
      end else if (start_wr) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= cpu_addr;
        mem_wdata_q <= cpu_wdata;
      end else if (done) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
      end
      if (hit_inc && (hit_cnt_q != {CNT_W{1'b1}}))   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != {CNT_W{1'b1}})) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign cpu_rdata = rd_out;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
Parametrised 2-way set-associative, write-through, no-write-allocate data cache for the MEM stage of the pipeline CPU.
- Sits between the CPU memory port and the backing data memory.
- Read hits complete combinationally in the same cycle.
- Read misses and all writes run through a small FSM with a req/ack handshake to memory; the CPU is stalled via cpu_ready.
- One-word blocks, true LRU per set, and saturating hit/miss counters.

Parameters:
ADDR_W, 8, word-address width
DATA_W, 16, data word width
SET_BITS, 2, log2(number of sets); tag width TAG_W = ADDR_W - SET_BITS
CNT_W, 16, width of hit/miss statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
cpu_req  in  1  access request; held stable with its operands until cpu_ready=1
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address; set=[SET_BITS-1:0], tag=[ADDR_W-1:SET_BITS]
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid when cpu_ready & cpu_req & !cpu_we
cpu_ready  out  1  access completes this cycle
hit  out  1  combinational lookup hit for the current cpu_addr
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle memory completion pulse
hit_cnt  out  CNT_W  saturating count of read hits
miss_cnt  out  CNT_W  saturating count of read misses

Behaviour:
- Reset (rst=0 at a clk edge):
  - All valid bits and LRU bits cleared.
  - FSM to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - hit_cnt=0, miss_cnt=0, cpu_rdata=0.
- Reset mid-transaction: the request is abandoned; mem_req is low the cycle after reset; a late mem_ack is ignored.
- Lookup: hit_w[i] = valid[i][set] & (tag[i][set]==cpu_addr tag). hit = |hit_w. Both ways must never hit together.
- FSM states: IDLE, FILL, WRITE.
- IDLE, no cpu_req: cpu_ready=1, no action.
- IDLE, read hit:
  - cpu_ready=1 and cpu_rdata = data of the hitting way, same cycle.
  - lru[set] <= index of the other way.
  - hit_cnt +1.
- IDLE, read miss:
  - cpu_ready=0; miss_cnt +1, counted once per miss.
  - Next state FILL; register mem_addr=cpu_addr, mem_we=0, mem_req=1.
- FILL:
  - Hold mem_req until mem_ack.
  - Victim selection on ack: first invalid way, lowest index first; otherwise way lru[set].
  - Write valid/tag/data into the victim; lru[set] <= other way.
  - cpu_rdata=mem_rdata and cpu_ready=1 in the ack cycle; return to IDLE.
- IDLE, write (hit or miss):
  - cpu_ready=0; next state WRITE.
  - Register mem_addr, mem_wdata=cpu_wdata, mem_we=1, mem_req=1.
- WRITE, on mem_ack:
  - If the address hits, update that way's data and LRU.
  - A miss does not allocate.
  - cpu_ready=1; return to IDLE.
- mem_req deasserts the cycle after mem_ack. A new request may issue in IDLE in the following cycle.
- Counters saturate at all-ones; no wrap.
- cpu_rdata holds its last value when not driven.
- Latency:
  - read hit 0 extra cycles
  - read miss 1 + memory latency
  - write 1 + memory latency

Decomposition:
- Shared package dcache_pkg:
  - state enum {IDLE, FILL, WRITE}
  - way index type (1 bit)
  - localparams TAG_W and NSETS = 1<<SET_BITS
- One sub-module dcache_way_array, instantiated twice: per-way valid/tag/data storage.
  - Combinational read port.
  - Synchronous write port and synchronous clear on rst.
- LRU bits, FSM and counters live in the top level.

Test Plan:
1. Reset, read 0x05; mem_ack 3 cycles later with mem_rdata=0xBEEF -> mem_req/mem_addr=0x05 high until ack; cpu_rdata=0xBEEF with cpu_ready in the ack cycle. Re-read 0x05 -> hit=1, cpu_ready same cycle, no mem_req.
2. Fill 0x01 then 0x05 (both set 1), read 0x01, read 0x09 (miss) -> 0x05 evicted. Then read 0x01 -> hit; read 0x05 -> miss.
3. Write 0x05=0x1234 while 0x05 is cached -> mem_req, mem_we=1, mem_wdata=0x1234. After ack, read 0x05 -> hit, 0x1234.
4. Write miss to 0x22 -> memory write only. Subsequent read 0x22 -> miss, miss_cnt increments.
5. Assert rst two cycles into a FILL for 0x10 -> mem_req=0 the next cycle, late mem_ack ignored, read 0x10 misses, counters are 0.
6. 3 read hits and 2 read misses -> hit_cnt=3, miss_cnt=2. With CNT_W=2, 5 misses -> miss_cnt saturates at 3.
